// File: rtl/map_req_arbiter_if.sv
// Agent-side handshake bundle for map_req_arbiter: per-requester request level,
// type and tile address in; one-hot ack/nack/wr pulses and the tile word out.
interface map_req_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req;
    logic [2*N_REQ-1:0]      req_type;
    logic [ADDR_W*N_REQ-1:0] req_content;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        nack;
    logic [N_REQ-1:0]        wr;
    logic [DATA_W-1:0]       data_out;

    modport master (
        output req, req_type, req_content,
        input  ack, nack, wr, data_out
    );

    modport slave (
        input  req, req_type, req_content,
        output ack, nack, wr, data_out
    );
endinterface

// File: rtl/map_req_arbiter.sv
// Round-robin arbiter in front of the single-port map BRAM; performs tile READ,
// DIG and PROBE with a fixed 4-cycle occupancy. Optional MAP_ARB_STATS_EN adds
// saturating grant/nack counters.
module map_req_arbiter #(
    parameter int                N_REQ      = 4,
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 16,
    parameter logic [1:0]        WALL_KIND  = 2'b10,
    parameter logic [DATA_W-1:0] EMPTY_TILE = '0
) (
    input  logic              clk,
    input  logic              rst,
    map_req_arbiter_if.slave  ifc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
`ifdef MAP_ARB_STATS_EN
    ,
    output logic [15:0]       stat_grants,
    output logic [15:0]       stat_nacks
`endif
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        type_q, type_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [N_REQ-1:0]  ack_q, ack_d, nack_q, nack_d, wr_q, wr_d;
    logic              grant_found_s;
    int                grant_i_s;
    logic [N_REQ-1:0]  resp_oh_s;
    logic [1:0]        kind_s;
`ifdef MAP_ARB_STATS_EN
    logic [15:0]       stat_grants_q, stat_grants_d;
    logic [15:0]       stat_nacks_q, stat_nacks_d;
`endif

    // Next-state, round-robin search and response decode
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        type_d     = type_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        mem_din_d  = mem_din_q;
        data_out_d = data_out_q;
        ack_d      = '0;
        nack_d     = '0;
        wr_d       = '0;

        // Search starts just after the last winner so nobody repeats while others wait
        grant_found_s = 1'b0;
        grant_i_s     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            int cand_i;
            cand_i = (int'(rr_ptr_q) + i) % N_REQ;
            if (!grant_found_s && ifc.req[cand_i]) begin
                grant_found_s = 1'b1;
                grant_i_s     = cand_i;
            end else begin
                grant_found_s = grant_found_s;
            end
        end

        resp_oh_s        = '0;
        resp_oh_s[idx_q] = 1'b1;
        kind_s           = mem_dout[DATA_W-1 -: 2];

        case (state_q)
            S_IDLE: begin
                if (grant_found_s) begin
                    idx_d      = IDX_W'(grant_i_s);
                    rr_ptr_d   = IDX_W'(grant_i_s);
                    type_d     = ifc.req_type[2*grant_i_s +: 2];
                    mem_addr_d = ifc.req_content[ADDR_W*grant_i_s +: ADDR_W];
                    state_d    = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                data_out_d = mem_dout;
                state_d    = S_RESP;
                case (type_q)
                    2'b00: begin
                        ack_d = resp_oh_s;
                        wr_d  = resp_oh_s;
                    end
                    2'b01: begin
                        if (kind_s == WALL_KIND) begin
                            nack_d = resp_oh_s;
                        end else begin
                            ack_d     = resp_oh_s;
                            mem_we_d  = 1'b1;
                            mem_din_d = EMPTY_TILE;
                        end
                    end
                    2'b10: begin
                        wr_d = resp_oh_s;
                        if (kind_s == 2'b00) begin
                            ack_d = resp_oh_s;
                        end else begin
                            nack_d = resp_oh_s;
                        end
                    end
                    default: nack_d = resp_oh_s;
                endcase
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef MAP_ARB_STATS_EN
        if ((state_q == S_IDLE) && grant_found_s && (stat_grants_q != 16'hFFFF)) begin
            stat_grants_d = stat_grants_q + 16'd1;
        end else begin
            stat_grants_d = stat_grants_q;
        end
        if ((|nack_d) && (stat_nacks_q != 16'hFFFF)) begin
            stat_nacks_d = stat_nacks_q + 16'd1;
        end else begin
            stat_nacks_d = stat_nacks_q;
        end
`endif
    end

    // State and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= IDX_W'(N_REQ - 1);
            idx_q      <= '0;
            type_q     <= 2'b00;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            data_out_q <= '0;
            ack_q      <= '0;
            nack_q     <= '0;
            wr_q       <= '0;
`ifdef MAP_ARB_STATS_EN
            stat_grants_q <= 16'h0000;
            stat_nacks_q  <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
            type_q     <= type_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            wr_q       <= wr_d;
`ifdef MAP_ARB_STATS_EN
            stat_grants_q <= stat_grants_d;
            stat_nacks_q  <= stat_nacks_d;
`endif
        end
    end

    assign ifc.ack      = ack_q;
    assign ifc.nack     = nack_q;
    assign ifc.wr       = wr_q;
    assign ifc.data_out = data_out_q;
    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_din      = mem_din_q;
`ifdef MAP_ARB_STATS_EN
    assign stat_grants  = stat_grants_q;
    assign stat_nacks   = stat_nacks_q;
`endif
endmodule

// File: tb/tb_map_req_arbiter.sv
// Directed scoreboard bench for map_req_arbiter with a behavioural BRAM.
module tb_map_req_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'h00;
    logic [15:0] ld_data = 16'h0000;
    logic [15:0] bram [256];
    logic [15:0] ref_mem [256];
`ifdef MAP_ARB_STATS_EN
    logic [15:0] stat_grants;
    logic [15:0] stat_nacks;
`endif

    typedef struct {
        logic [3:0]  ack;
        logic [3:0]  nack;
        logic [3:0]  wr;
        logic [15:0] data;
        logic        we;
        logic [15:0] din;
        logic [7:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    map_req_arbiter_if ifc ();

    map_req_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .ifc      (ifc),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
`ifdef MAP_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_nacks  (stat_nacks)
`endif
    );

    always #5 clk = ~clk;

    // Single-port BRAM, read-first, with a bench preload port
    always @(posedge clk) begin
        if (ld_en) bram[ld_addr] <= ld_data;
        else if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    function automatic void model(input int i, input logic [1:0] t, input logic [7:0] a);
        exp_t        e;
        logic [15:0] old;
        logic [3:0]  oh;
        oh  = 4'b0001 << i;
        old = ref_mem[a];
        e   = '{ack: 4'h0, nack: 4'h0, wr: 4'h0, data: old, we: 1'b0, din: 16'h0000, addr: a};
        case (t)
            2'b00: begin e.ack = oh; e.wr = oh; end
            2'b01: begin
                if (old[15:14] == 2'b10) e.nack = oh;
                else begin e.ack = oh; e.we = 1'b1; e.din = 16'h0000; ref_mem[a] = 16'h0000; end
            end
            2'b10: begin
                e.wr = oh;
                if (old[15:14] == 2'b00) e.ack = oh; else e.nack = oh;
            end
            default: e.nack = oh;
        endcase
        exp_q.push_back(e);
    endfunction

    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, "_qnonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_ack"},  32'(ifc.ack),      32'(e.ack));
            chk({tag, "_nack"}, 32'(ifc.nack),     32'(e.nack));
            chk({tag, "_wr"},   32'(ifc.wr),       32'(e.wr));
            chk({tag, "_data"}, 32'(ifc.data_out), 32'(e.data));
            chk({tag, "_we"},   32'(mem_we),       32'(e.we));
            if (e.we) begin
                chk({tag, "_din"},  32'(mem_din),  32'(e.din));
                chk({tag, "_addr"}, 32'(mem_addr), 32'(e.addr));
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after RESP.
    task automatic txn(input string tag, input int i, input logic [1:0] t, input logic [7:0] a);
        model(i, t, a);
        ifc.req_type[2*i +: 2]    = t;
        ifc.req_content[8*i +: 8] = a;
        ifc.req[i]                = 1'b1;
        @(posedge clk); #1;
        ifc.req[i] = 1'b0;
        @(negedge clk);
        chk({tag, "_issue_quiet"}, 32'({ifc.ack, ifc.nack, ifc.wr, mem_we}), 32'd0);
        @(negedge clk);
        chk({tag, "_wait_quiet"}, 32'({ifc.ack, ifc.nack, ifc.wr, mem_we}), 32'd0);
        @(negedge clk);
        check_resp(tag);
        @(negedge clk);
        chk({tag, "_after_quiet"}, 32'({ifc.ack, ifc.nack, ifc.wr, mem_we}), 32'd0);
    endtask

    initial begin
        ifc.req = 4'h0; ifc.req_type = 8'h00; ifc.req_content = 32'h0;
        poke(8'h5D, 16'h5D80);
        poke(8'h12, 16'h4000);
        poke(8'h30, 16'h8000);
        poke(8'h40, 16'h0000);
        poke(8'h41, 16'h4000);
        poke(8'h42, 16'h1234);
        poke(8'h50, 16'h4321);
        for (int k = 0; k < 4; k++) poke(8'h20 + 8'(k), 16'hA000 + 16'(k));
        @(negedge clk);
        chk("rst_outs",     32'({ifc.ack, ifc.nack, ifc.wr}), 32'd0);
        chk("rst_data_out", 32'(ifc.data_out), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we",   32'(mem_we), 32'd0);
        chk("rst_mem_din",  32'(mem_din), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        txn("read5d", 0, 2'b00, 8'h5D);
        txn("dig12",  1, 2'b01, 8'h12);
        txn("rd12",   2, 2'b00, 8'h12);
        txn("digwall", 1, 2'b01, 8'h30);
        txn("rd30",   0, 2'b00, 8'h30);
        txn("probe_empty", 2, 2'b10, 8'h40);
        txn("probe_full",  3, 2'b10, 8'h41);
        txn("rsvd",   1, 2'b11, 8'h42);
        txn("rd42",   1, 2'b00, 8'h42);

        // Reset asserted during WAIT of a DIG: no response, no write
        ifc.req_type[3:2] = 2'b01; ifc.req_content[15:8] = 8'h50; ifc.req[1] = 1'b1;
        @(posedge clk); #1;
        ifc.req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_now",  32'({ifc.ack, ifc.nack, ifc.wr, mem_we}), 32'd0);
        @(negedge clk);
        chk("abort_hold", 32'({ifc.ack, ifc.nack, ifc.wr, mem_we}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'({ifc.ack, ifc.nack, ifc.wr, mem_we}), 32'd0);
        txn("rd50_after_abort", 0, 2'b00, 8'h50);

        // Leave the pointer on requester 3, then hold all four requests
        txn("rd23", 3, 2'b00, 8'h23);
        for (int k = 0; k < 4; k++) begin
            ifc.req_type[2*k +: 2]    = 2'b00;
            ifc.req_content[8*k +: 8] = 8'h20 + 8'(k);
        end
        ifc.req = 4'hF;
        for (int t = 0; t < 8; t++) begin
            model(t % 4, 2'b00, 8'h20 + 8'(t % 4));
            @(posedge clk);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            check_resp($sformatf("fair%0d", t));
            @(posedge clk);
        end
        #1;
        ifc.req = 4'h0;
        @(negedge clk);
        chk("fair_quiet", 32'({ifc.ack, ifc.nack, ifc.wr, mem_we}), 32'd0);

`ifdef MAP_ARB_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("stat_rst", 32'({stat_grants, stat_nacks}), 32'd0);
        txn("s_rd0", 0, 2'b00, 8'h20);
        txn("s_rd1", 1, 2'b00, 8'h21);
        txn("s_rd2", 2, 2'b00, 8'h22);
        txn("s_wall0", 3, 2'b01, 8'h30);
        txn("s_wall1", 0, 2'b01, 8'h30);
        chk("stat_grants5", 32'(stat_grants), 32'd5);
        chk("stat_nacks2",  32'(stat_nacks),  32'd2);
        dut.stat_grants_q = 16'hFFFF;
        txn("s_sat", 1, 2'b00, 8'h21);
        chk("stat_grants_sat", 32'(stat_grants), 32'h0000FFFF);
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
